// File: rtl/control_seq_if.sv
// Datapath-facing bundle of the control sequencer: decode inputs, handshake and every control line.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface control_seq_if;
    logic [5:0] opcode;
    logic       z;
    logic       s;
    logic       o;
    logic       p;
    logic       ext_ack;
    logic       run;

    logic       s_inc;
    logic       s_inm;
    logic       s_rgj;
    logic       we3;
    logic       wez;
    logic       wes;
    logic       weo;
    logic       wep;
    logic       wed;
    logic       wext;
    logic       rws;
    logic       wsp;
    logic       wed_ext;
    logic       wess;
    logic [1:0] wro;
    logic       pc_en;
    logic       ext_req;
    logic       halted;
    logic       bus_err;
    logic       illegal;

    modport master (
        input  opcode, z, s, o, p, ext_ack, run,
        output s_inc, s_inm, s_rgj, we3, wez, wes, weo, wep, wed, wext, rws, wsp,
               wed_ext, wess, wro, pc_en, ext_req, halted, bus_err, illegal
    );

    modport slave (
        output opcode, z, s, o, p, ext_ack, run,
        input  s_inc, s_inm, s_rgj, we3, wez, wes, weo, wep, wed, wext, rws, wsp,
               wed_ext, wess, wro, pc_en, ext_req, halted, bus_err, illegal
    );
endinterface

// File: rtl/control_seq.sv
// Control unit and sequencer for the single-cycle CPU: opcode/flag decode, PC stall during
// external memory accesses with a bounded wait, HALT/resume and sticky error flags.
module control_seq #(
    parameter int TIMEOUT = 16
) (
    input logic          clk,
    input logic          reset,
    control_seq_if.master bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EXT_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       s_rgj;
        logic       we3;
        logic       wez;
        logic       wes;
        logic       weo;
        logic       wep;
        logic       wed;
        logic       wext;
        logic       rws;
        logic       wsp;
        logic       wed_ext;
        logic       wess;
        logic [1:0] wro;
        logic       pc_en;
        logic       ext_req;
        logic       halted;
    } ctrl_t;

    localparam logic [5:0] OP_ADDI = 6'b010000;
    localparam logic [5:0] OP_LD   = 6'b010001;
    localparam logic [5:0] OP_ST   = 6'b010010;
    localparam logic [5:0] OP_LDX  = 6'b010011;
    localparam logic [5:0] OP_STX  = 6'b010100;
    localparam logic [5:0] OP_OUT  = 6'b010101;
    localparam logic [5:0] OP_PUSH = 6'b010110;
    localparam logic [5:0] OP_POP  = 6'b010111;
    localparam logic [5:0] OP_J    = 6'b100000;
    localparam logic [5:0] OP_JZ   = 6'b100001;
    localparam logic [5:0] OP_JNZ  = 6'b100010;
    localparam logic [5:0] OP_JS   = 6'b100011;
    localparam logic [5:0] OP_JO   = 6'b100100;
    localparam logic [5:0] OP_JP   = 6'b100101;
    localparam logic [5:0] OP_JR   = 6'b100110;
    localparam logic [5:0] OP_CALL = 6'b100111;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [1:0] WRO_ALU = 2'b00;
    localparam logic [1:0] WRO_PC1 = 2'b01;
    localparam logic [1:0] WRO_STK = 2'b10;
    localparam logic [1:0] WRO_MEM = 2'b11;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       ext_store, ext_store_next;
    logic       bus_err, bus_err_next;
    logic       illegal, illegal_next;
    ctrl_t      ctrl, ctrl_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            ext_store <= 1'b0;
            bus_err   <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            ext_store <= ext_store_next;
            bus_err   <= bus_err_next;
            illegal   <= illegal_next;
        end
    end

    always_comb begin
        ctrl           = '0;
        ctrl.s_inc     = 1'b1;
        ctrl.pc_en     = 1'b1;
        state_next     = state;
        wait_cnt_next  = wait_cnt;
        ext_store_next = ext_store;
        bus_err_next   = bus_err;
        illegal_next   = illegal;

        case (state)
            RUN: begin
                casez (bus.opcode)
                    6'b000???: begin
                        ctrl.we3 = 1'b1;
                        ctrl.wez = 1'b1;
                        ctrl.wes = 1'b1;
                        ctrl.weo = 1'b1;
                        ctrl.wep = 1'b1;
                        ctrl.wro = WRO_ALU;
                    end
                    OP_ADDI: begin
                        ctrl.s_inm = 1'b1;
                        ctrl.we3   = 1'b1;
                        ctrl.wez   = 1'b1;
                        ctrl.wes   = 1'b1;
                        ctrl.weo   = 1'b1;
                        ctrl.wep   = 1'b1;
                    end
                    OP_LD: begin
                        ctrl.s_inm = 1'b1;
                        ctrl.we3   = 1'b1;
                        ctrl.wro   = WRO_MEM;
                    end
                    OP_ST: begin
                        ctrl.s_inm = 1'b1;
                        ctrl.wed   = 1'b1;
                    end
                    OP_LDX, OP_STX: begin
                        ctrl.s_inm   = 1'b1;
                        ctrl.ext_req = 1'b1;
                        ctrl.wed_ext = (bus.opcode == OP_STX);
                        // A same-cycle ack finishes the access with no stall at all
                        if (bus.ext_ack) begin
                            if (bus.opcode == OP_LDX) begin
                                ctrl.we3  = 1'b1;
                                ctrl.wro  = WRO_MEM;
                                ctrl.wext = 1'b1;
                            end
                        end else begin
                            ctrl.pc_en     = 1'b0;
                            wait_cnt_next  = 8'd0;
                            ext_store_next = (bus.opcode == OP_STX);
                            state_next     = EXT_WAIT;
                        end
                    end
                    OP_OUT: ctrl.wess = 1'b1;
                    OP_PUSH: ctrl.wsp = 1'b1;
                    OP_POP: begin
                        ctrl.wsp = 1'b1;
                        ctrl.rws = 1'b1;
                        ctrl.we3 = 1'b1;
                        ctrl.wro = WRO_STK;
                    end
                    OP_J:   ctrl.s_inc = 1'b0;
                    OP_JZ:  ctrl.s_inc = !bus.z;
                    OP_JNZ: ctrl.s_inc = bus.z;
                    OP_JS:  ctrl.s_inc = !bus.s;
                    OP_JO:  ctrl.s_inc = !bus.o;
                    OP_JP:  ctrl.s_inc = !bus.p;
                    OP_JR: begin
                        ctrl.s_inc = 1'b0;
                        ctrl.s_rgj = 1'b1;
                    end
                    OP_CALL: begin
                        ctrl.s_inc = 1'b0;
                        ctrl.we3   = 1'b1;
                        ctrl.wro   = WRO_PC1;
                    end
                    OP_HALT: begin
                        ctrl.pc_en = 1'b0;
                        state_next = HALTED;
                    end
                    default: illegal_next = 1'b1;
                endcase
            end

            EXT_WAIT: begin
                ctrl.s_inm   = 1'b1;
                ctrl.ext_req = 1'b1;
                ctrl.wed_ext = ext_store;
                ctrl.pc_en   = 1'b0;
                if (bus.ext_ack) begin
                    ctrl.pc_en = 1'b1;
                    if (!ext_store) begin
                        ctrl.we3  = 1'b1;
                        ctrl.wro  = WRO_MEM;
                        ctrl.wext = 1'b1;
                    end
                    state_next = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Abort: retire the instruction without writing anything back
                    ctrl.pc_en   = 1'b1;
                    bus_err_next = 1'b1;
                    state_next   = RUN;
                end else begin
                    wait_cnt_next = 8'(wait_cnt + 8'd1);
                end
            end

            HALTED: begin
                ctrl.halted = 1'b1;
                ctrl.pc_en  = 1'b0;
                if (bus.run) begin
                    ctrl.pc_en = 1'b1;
                    state_next = RUN;
                end
            end

            default: state_next = RUN;
        endcase
    end

    assign ctrl_out = reset ? '0 : ctrl;

    assign bus.s_inc   = ctrl_out.s_inc;
    assign bus.s_inm   = ctrl_out.s_inm;
    assign bus.s_rgj   = ctrl_out.s_rgj;
    assign bus.we3     = ctrl_out.we3;
    assign bus.wez     = ctrl_out.wez;
    assign bus.wes     = ctrl_out.wes;
    assign bus.weo     = ctrl_out.weo;
    assign bus.wep     = ctrl_out.wep;
    assign bus.wed     = ctrl_out.wed;
    assign bus.wext    = ctrl_out.wext;
    assign bus.rws     = ctrl_out.rws;
    assign bus.wsp     = ctrl_out.wsp;
    assign bus.wed_ext = ctrl_out.wed_ext;
    assign bus.wess    = ctrl_out.wess;
    assign bus.wro     = ctrl_out.wro;
    assign bus.pc_en   = ctrl_out.pc_en;
    assign bus.ext_req = ctrl_out.ext_req;
    assign bus.halted  = ctrl_out.halted;
    assign bus.bus_err = bus_err & ~reset;
    assign bus.illegal = illegal & ~reset;

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: the driver queues a hand-computed output vector per cycle,
// a negedge monitor pops and compares it against the live outputs.
module tb_control_seq;

    localparam logic [20:0] S_INC   = 21'h1 << 20;
    localparam logic [20:0] S_INM   = 21'h1 << 19;
    localparam logic [20:0] S_RGJ   = 21'h1 << 18;
    localparam logic [20:0] WE3     = 21'h1 << 17;
    localparam logic [20:0] WEZ     = 21'h1 << 16;
    localparam logic [20:0] WES     = 21'h1 << 15;
    localparam logic [20:0] WEO     = 21'h1 << 14;
    localparam logic [20:0] WEP     = 21'h1 << 13;
    localparam logic [20:0] WED     = 21'h1 << 12;
    localparam logic [20:0] WEXT    = 21'h1 << 11;
    localparam logic [20:0] RWS     = 21'h1 << 10;
    localparam logic [20:0] WSP     = 21'h1 << 9;
    localparam logic [20:0] WED_EXT = 21'h1 << 8;
    localparam logic [20:0] WESS    = 21'h1 << 7;
    localparam logic [20:0] WRO_PC1 = 21'h1 << 5;
    localparam logic [20:0] WRO_STK = 21'h2 << 5;
    localparam logic [20:0] WRO_MEM = 21'h3 << 5;
    localparam logic [20:0] PC_EN   = 21'h1 << 4;
    localparam logic [20:0] EXT_REQ = 21'h1 << 3;
    localparam logic [20:0] HALTED  = 21'h1 << 2;
    localparam logic [20:0] BUS_ERR = 21'h1 << 1;
    localparam logic [20:0] ILLEGAL = 21'h1;

    localparam logic [20:0] DEF   = S_INC | PC_EN;
    localparam logic [20:0] FLAGS = WEZ | WES | WEO | WEP;

    localparam logic [5:0] OP_ALU  = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b010000;
    localparam logic [5:0] OP_LD   = 6'b010001;
    localparam logic [5:0] OP_ST   = 6'b010010;
    localparam logic [5:0] OP_LDX  = 6'b010011;
    localparam logic [5:0] OP_STX  = 6'b010100;
    localparam logic [5:0] OP_OUT  = 6'b010101;
    localparam logic [5:0] OP_PUSH = 6'b010110;
    localparam logic [5:0] OP_POP  = 6'b010111;
    localparam logic [5:0] OP_J    = 6'b100000;
    localparam logic [5:0] OP_JZ   = 6'b100001;
    localparam logic [5:0] OP_JNZ  = 6'b100010;
    localparam logic [5:0] OP_JS   = 6'b100011;
    localparam logic [5:0] OP_JR   = 6'b100110;
    localparam logic [5:0] OP_CALL = 6'b100111;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_BAD  = 6'b110000;

    typedef struct {
        logic [20:0] exp;
        string       name;
    } item_t;

    logic        clk;
    logic        reset;
    item_t       sb_q[$];
    int          compared;
    int          mismatched;
    logic [20:0] sticky;

    control_seq_if bus ();

    control_seq #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic [3:0] zsop,
                                 input logic ack, input logic rn, input logic [20:0] exp,
                                 input string name);
        @(posedge clk);
        #1;
        reset          = rst;
        bus.opcode     = op;
        {bus.z, bus.s, bus.o, bus.p} = zsop;
        bus.ext_ack    = ack;
        bus.run        = rn;
        sb_q.push_back('{rst ? exp : (exp | sticky), name});
    endtask

    task automatic checkOutput();
        item_t       it;
        logic [20:0] act;
        it  = sb_q.pop_front();
        act = {bus.s_inc, bus.s_inm, bus.s_rgj, bus.we3, bus.wez, bus.wes, bus.weo, bus.wep,
               bus.wed, bus.wext, bus.rws, bus.wsp, bus.wed_ext, bus.wess, bus.wro,
               bus.pc_en, bus.ext_req, bus.halted, bus.bus_err, bus.illegal};
        compared++;
        if (act !== it.exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b expected %b", it.name, act, it.exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) checkOutput();
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        sticky     = '0;
        reset      = 1'b1;
        bus.opcode = 6'd0;
        {bus.z, bus.s, bus.o, bus.p} = 4'b0000;
        bus.ext_ack = 1'b0;
        bus.run     = 1'b0;

        applyStimulus(1, OP_ALU, 4'b0000, 0, 0, '0, "reset_outputs");
        applyStimulus(1, OP_HALT, 4'b0000, 1, 1, '0, "reset_outputs_2");

        applyStimulus(0, OP_ALU,  4'b0000, 0, 0, DEF | WE3 | FLAGS, "alu");
        applyStimulus(0, OP_ADDI, 4'b0000, 0, 0, DEF | S_INM | WE3 | FLAGS, "addi");
        applyStimulus(0, OP_LD,   4'b0000, 0, 0, DEF | S_INM | WE3 | WRO_MEM, "ld");
        applyStimulus(0, OP_ST,   4'b0000, 0, 0, DEF | S_INM | WED, "st");
        applyStimulus(0, OP_OUT,  4'b0000, 0, 0, DEF | WESS, "out7seg");
        applyStimulus(0, OP_PUSH, 4'b0000, 0, 0, DEF | WSP, "push");
        applyStimulus(0, OP_POP,  4'b0000, 0, 0, DEF | WSP | RWS | WE3 | WRO_STK, "pop");
        applyStimulus(0, OP_J,    4'b0000, 0, 0, PC_EN, "j");
        applyStimulus(0, OP_JZ,   4'b1000, 0, 0, PC_EN, "jz_taken");
        applyStimulus(0, OP_JZ,   4'b0111, 0, 0, DEF, "jz_not_taken");
        applyStimulus(0, OP_JNZ,  4'b1000, 0, 0, DEF, "jnz_not_taken");
        applyStimulus(0, OP_JNZ,  4'b0000, 0, 0, PC_EN, "jnz_taken");
        applyStimulus(0, OP_JS,   4'b0100, 0, 0, PC_EN, "js_taken");
        applyStimulus(0, OP_JR,   4'b0000, 0, 0, PC_EN | S_RGJ, "jr");
        applyStimulus(0, OP_CALL, 4'b0000, 0, 0, PC_EN | WE3 | WRO_PC1, "call");
        applyStimulus(0, OP_ALU,  4'b0000, 1, 1, DEF | WE3 | FLAGS, "alu_ignores_ack_run");

        // LDX acknowledged on the third wait cycle
        applyStimulus(0, OP_LDX, 4'b0000, 0, 0, S_INC | S_INM | EXT_REQ, "ldx_issue");
        applyStimulus(0, OP_LDX, 4'b0000, 0, 0, S_INC | S_INM | EXT_REQ, "ldx_wait1");
        applyStimulus(0, OP_LDX, 4'b0000, 0, 0, S_INC | S_INM | EXT_REQ, "ldx_wait2");
        applyStimulus(0, OP_LDX, 4'b0000, 1, 0,
                      S_INC | S_INM | EXT_REQ | PC_EN | WE3 | WRO_MEM | WEXT, "ldx_complete");
        applyStimulus(0, OP_ALU, 4'b0000, 0, 0, DEF | WE3 | FLAGS, "after_ldx_run");

        applyStimulus(0, OP_STX, 4'b0000, 1, 0, DEF | S_INM | EXT_REQ | WED_EXT, "stx_zero_wait");
        applyStimulus(0, OP_ALU, 4'b0000, 0, 0, DEF | WE3 | FLAGS, "after_stx_run");

        // STX timing out with TIMEOUT=4: five request cycles, the last one aborts
        applyStimulus(0, OP_STX, 4'b0000, 0, 0, S_INC | S_INM | EXT_REQ | WED_EXT, "stx_to_issue");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, OP_STX, 4'b0000, 0, 0, S_INC | S_INM | EXT_REQ | WED_EXT, "stx_to_wait");
        applyStimulus(0, OP_STX, 4'b0000, 0, 0, DEF | S_INM | EXT_REQ | WED_EXT, "stx_to_abort");
        sticky = sticky | BUS_ERR;
        applyStimulus(0, OP_ALU, 4'b0000, 1, 0, DEF | WE3 | FLAGS, "bus_err_sticky");

        applyStimulus(0, OP_HALT, 4'b0000, 0, 0, S_INC, "halt_issue");
        for (int i = 0; i < 10; i++)
            applyStimulus(0, OP_HALT, 4'b1111, 1, 0, S_INC | HALTED, "halted_hold");
        applyStimulus(0, OP_HALT, 4'b0000, 0, 1, S_INC | HALTED | PC_EN, "halted_resume");
        applyStimulus(0, OP_ALU,  4'b0000, 0, 0, DEF | WE3 | FLAGS, "after_resume_run");

        applyStimulus(0, OP_BAD, 4'b0000, 0, 0, DEF, "illegal_nop");
        sticky = sticky | ILLEGAL;
        applyStimulus(0, OP_ST,  4'b0000, 0, 0, DEF | S_INM | WED, "illegal_sticky");

        // Reset landing on the second wait cycle of an LDX, with a late ack
        applyStimulus(0, OP_LDX, 4'b0000, 0, 0, S_INC | S_INM | EXT_REQ, "rst_ldx_issue");
        applyStimulus(0, OP_LDX, 4'b0000, 0, 0, S_INC | S_INM | EXT_REQ, "rst_ldx_wait1");
        applyStimulus(1, OP_LDX, 4'b0000, 1, 0, '0, "rst_mid_access");
        sticky = '0;
        applyStimulus(0, OP_ST,  4'b0000, 1, 0, DEF | S_INM | WED, "after_reset_run");

        @(negedge clk);
        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
